// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Opcodes, sequencer states, ALU and write-back codes, and the
//               branch-condition helper for the accumulator/register CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int OPC_W = 5;

   localparam logic [4:0] OP_STP = 5'b00000;
   localparam logic [4:0] OP_ADR = 5'b00001;
   localparam logic [4:0] OP_SBR = 5'b00010;
   localparam logic [4:0] OP_MLR = 5'b00011;
   localparam logic [4:0] OP_XSL = 5'b00100;
   localparam logic [4:0] OP_XSR = 5'b00101;
   localparam logic [4:0] OP_BBO = 5'b00110;
   localparam logic [4:0] OP_ADI = 5'b00111;
   localparam logic [4:0] OP_SBI = 5'b01000;
   localparam logic [4:0] OP_ADM = 5'b01001;
   localparam logic [4:0] OP_SBM = 5'b01010;
   localparam logic [4:0] OP_LDI = 5'b01011;
   localparam logic [4:0] OP_LDA = 5'b01100;
   localparam logic [4:0] OP_STA = 5'b01101;
   localparam logic [4:0] OP_LDR = 5'b01110;
   localparam logic [4:0] OP_STI = 5'b01111;
   localparam logic [4:0] OP_JMP = 5'b10000;
   localparam logic [4:0] OP_JEQ = 5'b10001;
   localparam logic [4:0] OP_JNQ = 5'b10010;
   localparam logic [4:0] OP_JMR = 5'b10011;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_EXEC1 = 3'd3,
      ST_EXEC2 = 3'd4,
      ST_HALT  = 3'd5
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_MUL = 3'd2;
   localparam logic [2:0] ALU_XSL = 3'd3;
   localparam logic [2:0] ALU_XSR = 3'd4;
   localparam logic [2:0] ALU_BBO = 3'd5;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_IMM = 2'd1;
   localparam logic [1:0] WB_MEM = 2'd2;

   function automatic logic jump_taken(input logic [4:0] opc,
                                       input logic       eq_flag,
                                       input logic       reg_cond);
      logic taken;
      case (opc)
         OP_JMP:  taken = 1'b1;
         OP_JEQ:  taken = eq_flag;
         OP_JNQ:  taken = ~eq_flag;
         OP_JMR:  taken = reg_cond;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_class_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_class_decode
// Description : Combinational opcode classifier with ALU / write-back /
//               address-source selection.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_class_decode
   import cpu_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       one_exec,
   output logic       two_exec,
   output logic       jump,
   output logic       store,
   output logic       stop,
   output logic       illegal,
   output logic [2:0] alu_op,
   output logic [1:0] wb_sel,
   output logic       addr_sel
);

   always_comb begin
      one_exec = 1'b0;
      two_exec = 1'b0;
      jump     = 1'b0;
      store    = 1'b0;
      stop     = 1'b0;
      illegal  = 1'b0;
      alu_op   = ALU_ADD;
      wb_sel   = WB_ALU;
      addr_sel = 1'b0;
      case (opcode)
         OP_ADR, OP_ADI: begin
            one_exec = 1'b1;
            alu_op   = ALU_ADD;
         end
         OP_SBR, OP_SBI: begin
            one_exec = 1'b1;
            alu_op   = ALU_SUB;
         end
         OP_MLR: begin
            one_exec = 1'b1;
            alu_op   = ALU_MUL;
         end
         OP_XSL: begin
            one_exec = 1'b1;
            alu_op   = ALU_XSL;
         end
         OP_XSR: begin
            one_exec = 1'b1;
            alu_op   = ALU_XSR;
         end
         OP_BBO: begin
            one_exec = 1'b1;
            alu_op   = ALU_BBO;
         end
         OP_LDI: begin
            one_exec = 1'b1;
            wb_sel   = WB_IMM;
         end
         OP_STA: begin
            one_exec = 1'b1;
            store    = 1'b1;
         end
         OP_STI: begin
            one_exec = 1'b1;
            store    = 1'b1;
            addr_sel = 1'b1;
         end
         // Memory-operand arithmetic adds the returned word through the ALU
         OP_ADM: begin
            two_exec = 1'b1;
            alu_op   = ALU_ADD;
         end
         OP_SBM: begin
            two_exec = 1'b1;
            alu_op   = ALU_SUB;
         end
         OP_LDA: begin
            two_exec = 1'b1;
            wb_sel   = WB_MEM;
         end
         OP_LDR: begin
            two_exec = 1'b1;
            wb_sel   = WB_MEM;
            addr_sel = 1'b1;
         end
         OP_JMP, OP_JEQ, OP_JNQ, OP_JMR: begin
            jump = 1'b1;
         end
         OP_STP: begin
            stop = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Phase state machine, instruction register and control decode
//               with data-ready stall, halt/resume and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int INSTR_W  = 16,
   parameter int DATA_W   = 16,
   parameter int NREGS    = 4,
   parameter int MAX_WAIT = 15,
   localparam int RSEL_W  = $clog2(NREGS)
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_q,
   input  logic               data_ready,
   input  logic               eq,
   input  logic               jmr_cond,
   input  logic               resume,
   output logic               instr_rden,
   output logic               data_rden,
   output logic               data_wren,
   output logic               addr_sel,
   output logic               pc_cnten,
   output logic               pc_sload,
   output logic [NREGS-1:0]   reg_wen,
   output logic [RSEL_W-1:0]  rd_sel,
   output logic [RSEL_W-1:0]  rs_sel,
   output logic [2:0]         alu_op,
   output logic [1:0]         wb_sel,
   output logic [DATA_W-1:0]  imm,
   output logic               halted,
   output logic               illegal,
   output logic               bus_error
);

   localparam int IMM_W = INSTR_W - OPC_W - 2 * RSEL_W;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT - 1);

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

   logic [OPC_W-1:0]   w_opcode;
   logic [NREGS-1:0]   w_rd_onehot;
   logic               w_one_exec, w_two_exec, w_jump, w_store, w_stop, w_illegal;
   logic [2:0]         w_alu_op;
   logic [1:0]         w_wb_sel;
   logic               w_addr_sel;

   assign w_opcode    = ir_q[INSTR_W-1 -: OPC_W];
   assign rd_sel      = ir_q[INSTR_W-OPC_W-1 -: RSEL_W];
   assign rs_sel      = ir_q[INSTR_W-OPC_W-RSEL_W-1 -: RSEL_W];
   assign w_rd_onehot = {{(NREGS-1){1'b0}}, 1'b1} << rd_sel;

   generate
      if (DATA_W > IMM_W) begin : g_imm_zext
         assign imm = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
      end else begin : g_imm_fit
         assign imm = ir_q[DATA_W-1:0];
      end
   endgenerate

   instr_class_decode u_decode (
      .opcode   (w_opcode),
      .one_exec (w_one_exec),
      .two_exec (w_two_exec),
      .jump     (w_jump),
      .store    (w_store),
      .stop     (w_stop),
      .illegal  (w_illegal),
      .alu_op   (w_alu_op),
      .wb_sel   (w_wb_sel),
      .addr_sel (w_addr_sel)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ir_q       <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Counter defaults to zero so it is already clear on every EXEC2 entry
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      wait_cnt_d = '0;
      instr_rden = 1'b0;
      data_rden  = 1'b0;
      data_wren  = 1'b0;
      addr_sel   = 1'b0;
      pc_cnten   = 1'b0;
      pc_sload   = 1'b0;
      reg_wen    = '0;
      alu_op     = ALU_ADD;
      wb_sel     = WB_ALU;
      halted     = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            instr_rden = 1'b1;
            state_d    = ST_LOAD;
         end
         ST_LOAD: begin
            ir_d    = instr_q;
            state_d = ST_EXEC1;
         end
         ST_EXEC1: begin
            state_d  = ST_FETCH;
            alu_op   = w_alu_op;
            wb_sel   = w_wb_sel;
            addr_sel = w_addr_sel;
            if (w_illegal) begin
               illegal  = 1'b1;
               pc_cnten = 1'b1;
            end else if (w_stop) begin
               state_d = ST_HALT;
            end else if (w_jump) begin
               if (jump_taken(w_opcode, eq, jmr_cond)) begin
                  pc_sload = 1'b1;
               end else begin
                  pc_cnten = 1'b1;
               end
            end else if (w_two_exec) begin
               data_rden = 1'b1;
               state_d   = ST_EXEC2;
            end else if (w_store) begin
               data_wren = 1'b1;
               pc_cnten  = 1'b1;
            end else if (w_one_exec) begin
               reg_wen  = w_rd_onehot;
               pc_cnten = 1'b1;
            end
         end
         ST_EXEC2: begin
            alu_op   = w_alu_op;
            wb_sel   = w_wb_sel;
            addr_sel = w_addr_sel;
            // A ready arriving on the final allowed cycle still completes the load
            if (data_ready) begin
               reg_wen  = w_rd_onehot;
               pc_cnten = 1'b1;
               state_d  = ST_FETCH;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
               bus_error = 1'b1;
               pc_cnten  = 1'b1;
               state_d   = ST_FETCH;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
               state_d    = ST_EXEC2;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            if (resume) begin
               pc_cnten = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
